// File: rtl/mod_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : mod_operand_stage
// Purpose  : Registered operand staging in front of the combinational modulo
//            unit. Two-entry skid buffer (main + skid) on a valid/ready
//            handshake so in_ready comes straight from a flop.
// Options  : MOD_ZERO_GUARD_EN - replace a zero divisor with 1, flag the pair
//            on out_dz and keep a saturating count of flagged deliveries.
// Revision : 1.0 - initial release
// ============================================================================
module mod_operand_stage #(
   parameter int DATAWIDTH  = 8,
   parameter int COUNTWIDTH = 8
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATAWIDTH-1:0]  in_a,
   input  logic [DATAWIDTH-1:0]  in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATAWIDTH-1:0]  out_a,
   output logic [DATAWIDTH-1:0]  out_b,
   output logic                  out_dz,
   output logic [COUNTWIDTH-1:0] dz_count
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic [DATAWIDTH-1:0]  r_main_a;
   logic [DATAWIDTH-1:0]  r_main_b;
   logic [DATAWIDTH-1:0]  r_skid_a;
   logic [DATAWIDTH-1:0]  r_skid_b;

   logic                  w_accept;
   logic                  w_deliver;
   logic                  w_load_main_in;
   logic                  w_load_main_skid;
   logic                  w_load_skid;
   logic [DATAWIDTH-1:0]  w_in_b;

   assign w_accept  = in_valid && r_in_ready;
   assign w_deliver = r_out_valid && out_ready;

   // New pair goes to main when main is empty or being drained; otherwise to skid.
   // Skid refills main whenever the downstream takes the current pair.
   assign w_load_main_in   = w_accept && ((r_state == S_EMPTY) ||
                                          ((r_state == S_ONE) && out_ready));
   assign w_load_skid      = w_accept && (r_state == S_ONE) && !out_ready;
   assign w_load_main_skid = (r_state == S_FULL) && out_ready;

   // Handshake FSM with registered in_ready/out_valid
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state     <= S_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  r_state     <= S_ONE;
                  r_out_valid <= 1'b1;
               end
            end
            S_ONE: begin
               if (w_accept && !w_deliver) begin
                  r_state    <= S_FULL;
                  r_in_ready <= 1'b0;
               end else if (!w_accept && w_deliver) begin
                  r_state     <= S_EMPTY;
                  r_out_valid <= 1'b0;
               end
            end
            S_FULL: begin
               if (w_deliver) begin
                  r_state    <= S_ONE;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Operand storage for main and skid entries
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_main_a <= '0;
         r_main_b <= '0;
         r_skid_a <= '0;
         r_skid_b <= '0;
      end else begin
         if (w_load_main_in) begin
            r_main_a <= in_a;
            r_main_b <= w_in_b;
         end else if (w_load_main_skid) begin
            r_main_a <= r_skid_a;
            r_main_b <= r_skid_b;
         end
         if (w_load_skid) begin
            r_skid_a <= in_a;
            r_skid_b <= w_in_b;
         end
      end
   end

`ifdef MOD_ZERO_GUARD_EN
   logic                  w_in_dz;
   logic                  r_main_dz;
   logic                  r_skid_dz;
   logic [COUNTWIDTH-1:0] r_dz_count;

   // A zero divisor becomes 1 so the remainder downstream is simply 0
   assign w_in_dz = (in_b == '0);
   assign w_in_b  = w_in_dz ? DATAWIDTH'(1) : in_b;

   // Zero-divisor flag follows its pair through main/skid
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_main_dz <= 1'b0;
         r_skid_dz <= 1'b0;
      end else begin
         if (w_load_main_in) begin
            r_main_dz <= w_in_dz;
         end else if (w_load_main_skid) begin
            r_main_dz <= r_skid_dz;
         end
         if (w_load_skid) begin
            r_skid_dz <= w_in_dz;
         end
      end
   end

   // Saturating count of flagged pairs actually handed downstream
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_dz_count <= '0;
      end else if (w_deliver && r_main_dz && (r_dz_count != {COUNTWIDTH{1'b1}})) begin
         r_dz_count <= r_dz_count + COUNTWIDTH'(1);
      end
   end

   assign out_dz   = r_main_dz;
   assign dz_count = r_dz_count;
`else
   assign w_in_b   = in_b;
   assign out_dz   = 1'b0;
   assign dz_count = '0;
`endif

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_a     = r_main_a;
   assign out_b     = r_main_b;

endmodule
`default_nettype wire

// File: tb/tb_mod_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_operand_stage
// Purpose  : Self-checking bench for mod_operand_stage. Accepted pairs are
//            pushed to a scoreboard queue; delivered pairs are popped and
//            compared. Directed checks cover reset, latency, backpressure,
//            zero-divisor handling and reset while full.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_operand_stage;

   localparam int DW = 8;
   localparam int CW = 8;
`ifdef MOD_ZERO_GUARD_EN
   localparam bit c_guard = 1'b1;
`else
   localparam bit c_guard = 1'b0;
`endif

   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic          dz;
   } pair_t;

   logic          Clk = 1'b0;
   logic          Rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_a = '0;
   logic [DW-1:0] in_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_a;
   logic [DW-1:0] out_b;
   logic          out_dz;
   logic [CW-1:0] dz_count;

   pair_t q_exp[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    n_deliv = 0;
   int    exp_cnt = 0;

   mod_operand_stage #(.DATAWIDTH(DW), .COUNTWIDTH(CW)) u_dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_dz    (out_dz),
      .dz_count  (dz_count)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic pair_t model(input logic [DW-1:0] a, input logic [DW-1:0] b);
      pair_t p;
      p.a  = a;
      p.b  = (c_guard && b == '0) ? DW'(1) : b;
      p.dz = c_guard && (b == '0);
      return p;
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Scoreboard: push on accept, pop/compare on delivery (sampled mid-cycle)
   always @(negedge Clk) begin
      if (!Rst) begin
         if (in_valid && in_ready) q_exp.push_back(model(in_a, in_b));
         if (out_valid && out_ready) begin
            n_deliv++;
            if (q_exp.size() == 0) begin
               check("sb_unexpected_output", 32'(out_a), 32'hFFFF_FFFF);
            end else begin
               pair_t e;
               e = q_exp.pop_front();
               check("sb_a",  32'(out_a),  32'(e.a));
               check("sb_b",  32'(out_b),  32'(e.b));
               check("sb_dz", 32'(out_dz), 32'(e.dz));
               if (e.dz && exp_cnt < (1 << CW) - 1) exp_cnt++;
            end
         end
      end
   end

   task automatic drain(input string tag);
      int budget = 400;
      while (q_exp.size() != 0 && budget > 0) begin
         step();
         budget--;
      end
      check(tag, 32'(q_exp.size()), 32'd0);
   endtask

   initial begin
      pair_t first;
      // Reset state
      repeat (3) @(posedge Clk);
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_a",     32'(out_a),     32'd0);
      check("rst_out_b",     32'(out_b),     32'd0);
      check("rst_out_dz",    32'(out_dz),    32'd0);
      check("rst_dz_count",  32'(dz_count),  32'd0);
      Rst = 1'b0;
      step();

      // Single pair, one-cycle latency then idle
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 8'h2B; in_b = 8'h05;
      step();
      in_valid = 1'b0;
      check("single_valid", 32'(out_valid), 32'd1);
      check("single_a",     32'(out_a),     32'h2B);
      check("single_b",     32'(out_b),     32'h05);
      step();
      check("single_idle",  32'(out_valid), 32'd0);

      // Ten-pair stream at full rate
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_a = DW'(i); in_b = DW'(i + 1);
         check("stream_in_ready", 32'(in_ready), 32'd1);
         step();
         check("stream_valid", 32'(out_valid), 32'd1);
         check("stream_a",     32'(out_a),     32'(i));
      end
      in_valid = 1'b0;
      drain("stream_drain");
      step();
      check("stream_idle", 32'(out_valid), 32'd0);

      // Backpressure: ONE then FULL, third pair stalls
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 8'hA1; in_b = 8'h11;
      step();
      check("bp_ready_one", 32'(in_ready), 32'd1);
      in_a = 8'hA2; in_b = 8'h22;
      step();
      check("bp_ready_full", 32'(in_ready), 32'd0);
      in_a = 8'hA3; in_b = 8'h33;
      for (int k = 0; k < 5; k++) begin
         step();
         check("bp_stall_ready", 32'(in_ready),  32'd0);
         check("bp_hold_valid",  32'(out_valid), 32'd1);
         check("bp_hold_a",      32'(out_a),     32'hA1);
         check("bp_hold_b",      32'(out_b),     32'h11);
      end
      check("bp_queue_depth", 32'(q_exp.size()), 32'd2);
      out_ready = 1'b1;
      step();                       // skid -> main, third pair still blocked
      check("bp_refill_a", 32'(out_a),    32'hA2);
      check("bp_ready_back", 32'(in_ready), 32'd1);
      step();                       // third pair accepted
      in_valid = 1'b0;
      check("bp_third_a", 32'(out_a), 32'hA3);
      drain("bp_drain");

      // Zero divisor handling
      first = model(8'h7F, 8'h00);
      in_valid = 1'b1; in_a = 8'h7F; in_b = 8'h00;
      step();
      in_valid = 1'b0;
      check("dz_first_a",  32'(out_a),  32'h7F);
      check("dz_first_b",  32'(out_b),  32'(first.b));
      check("dz_first_dz", 32'(out_dz), 32'(first.dz));
      step();
      check("dz_count_one", 32'(dz_count), c_guard ? 32'd1 : 32'd0);
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         in_a = DW'($urandom_range(0, 255)); in_b = 8'h00;
         step();
      end
      in_valid = 1'b0;
      drain("dz_drain");
      step();
      check("dz_count_model", 32'(dz_count), 32'(exp_cnt));
      check("dz_count_sat",   32'(dz_count), c_guard ? 32'hFF : 32'd0);

      // Mixed random traffic with random backpressure
      for (int i = 0; i < 60; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_a = DW'($urandom_range(0, 255));
         in_b = DW'($urandom_range(0, 3));
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      drain("rand_drain");

      // Reset while FULL discards everything
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 8'hC1; in_b = 8'h01;
      step();
      in_a = 8'hC2; in_b = 8'h02;
      step();
      in_valid = 1'b0;
      check("rf_full", 32'(in_ready), 32'd0);
      #2 Rst = 1'b1;
      #1;
      check("rf_out_valid", 32'(out_valid), 32'd0);
      check("rf_in_ready",  32'(in_ready),  32'd1);
      check("rf_dz_count",  32'(dz_count),  32'd0);
      q_exp.delete();
      exp_cnt = 0;
      step();
      Rst = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check("rf_no_stale", 32'(out_valid), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/mod_operand_stage.md
Name: mod_operand_stage

Overview:
- Registered operand staging block that sits directly upstream of the combinational modulo unit and feeds its a/b inputs.
- Accepts operand pairs on a valid/ready handshake and buffers them in a 2-entry skid buffer so in_ready is registered.
- Presents one stable operand pair per transfer to the modulo datapath.
- Optionally guards against a zero divisor.

Parameters:
DATAWIDTH, 8, width of operands a and b (matches the modulo unit's DATAWIDTH)
COUNTWIDTH, 8, width of the saturating zero-divisor event counter

Ports:
Clk  input  1  system clock, all state updates on rising edge
Rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream operand pair valid
in_ready  output  1  stage can accept; registered (function of state only)
in_a  input  DATAWIDTH  dividend
in_b  input  DATAWIDTH  divisor
out_valid  output  1  out_a/out_b hold a valid pair
out_ready  input  1  downstream (modulo result consumer) accepts pair
out_a  output  DATAWIDTH  dividend to modulo unit
out_b  output  DATAWIDTH  divisor to modulo unit
out_dz  output  1  current output pair had b==0 (guard build only)
dz_count  output  COUNTWIDTH  saturating count of zero-divisor pairs delivered (guard build only)

Behaviour:
- Reset (async assert, sync release on Clk): main and skid entries empty; out_valid=0, in_ready=1, out_a=0, out_b=0, out_dz=0, dz_count=0. Reset mid-transfer discards all buffered pairs, with no partial output.
- Transfers: input accepted when in_valid&&in_ready; output delivered when out_valid&&out_ready. in_valid must not depend on in_ready. out_a/out_b/out_dz hold stable while out_valid&&!out_ready.
- Storage: main register (drives outputs) plus skid register. in_ready = !skid_full.
- Accept, main empty or being drained this cycle (out_ready=1), skid empty: pair loads main.
- Accept, main full, out_ready=0: pair loads skid; in_ready drops to 0 next cycle.
- Skid full and out_ready=1: skid moves to main, skid empties, in_ready=1 next cycle. Any new input is blocked that cycle because in_ready=0.
- Simultaneous accept and deliver with skid empty: main replaced by new pair, out_valid stays 1.
- Deliver with no accept and skid empty: out_valid=0 next cycle.
- Latency: pair accepted in cycle N appears on outputs in cycle N+1 if the buffer is empty.
- Throughput: 1 pair/cycle sustained with out_ready held high. Strict FIFO order, no drop, no duplication.
- States:
  - EMPTY (main empty, skid empty)
  - ONE (main full, skid empty)
  - FULL (main full, skid full)
- Transitions:
  - EMPTY->ONE on accept.
  - ONE->EMPTY on deliver without accept.
  - ONE->FULL on accept without deliver.
  - FULL->ONE on deliver.
  - All other combinations hold the current state.
- No arithmetic on the data path; widths pass through unchanged.

Optional Feature:
- Macro: MOD_ZERO_GUARD_EN.
- When defined:
  - Pair accepted with in_b==0 is stored with out_b forced to 1 (downstream remainder becomes 0) and out_dz=1 for that pair.
  - out_a is unchanged.
  - dz_count increments by 1 on each delivered pair with out_dz=1 and saturates at 2^COUNTWIDTH-1.
- When undefined:
  - in_b passes through unmodified.
  - out_dz and dz_count are tied to 0; no counter logic is built.

Test Plan:
- Reset then single pair a=0x2B, b=0x05, out_ready=1 -> out_valid=1 one cycle after accept; out_a=0x2B, out_b=0x05; out_valid=0 the following cycle.
- Stream of 10 pairs (a=i, b=i+1) with out_ready=1 -> in_ready stays 1; outputs arrive in order, 1 per cycle, 1 cycle latency.
- out_ready=0, send 3 pairs -> first two accepted (ONE then FULL), in_ready=0, third stalls; after out_ready=1, all 3 delivered in order.
- Backpressure stability: out_ready=0 for 5 cycles with out_valid=1 -> out_a/out_b unchanged every cycle.
- Guard build, pair a=0x7F, b=0x00, then 300 zero-divisor pairs -> first delivered pair has out_b=0x01, out_dz=1, dz_count=1; dz_count saturates at 0xFF. Non-guard build: out_b=0x00, out_dz=0, dz_count=0.
- Assert Rst while FULL -> immediately out_valid=0, in_ready=1, dz_count=0; no stale pair delivered after release.
